// File: rtl/scope_trigger_ctrl_pkg.sv
// Shared definitions for the scope trigger controller.
// Holds the FSM state encoding, the trig_mode codes, the default widths
// and a helper that says which states write into the sample RAM.
package scope_trigger_ctrl_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 10;
    localparam int PRE_TRIG_DEF = 256;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRETRIG = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4,
        S_HOLDOFF = 3'd5
    } state_e;

    // Code 3 is treated exactly like normal.
    typedef enum logic [1:0] {
        MODE_AUTO       = 2'd0,
        MODE_NORMAL     = 2'd1,
        MODE_SINGLE     = 2'd2,
        MODE_NORMAL_ALT = 2'd3
    } trig_mode_e;

    function automatic logic is_capture(input state_e s);
        return (s == S_PRETRIG) || (s == S_ARMED) || (s == S_POST);
    endfunction

endpackage

// File: rtl/scope_trigger_ctrl_edge_detect.sv
// Trigger comparator.
// Keeps the previous sample (d1) and compares it with the current sample
// (d0) against an unsigned level, flagging a rising or falling crossing.
// Ports:
//   sys_clk_i    clock
//   rst_i        synchronous active-high reset
//   clr_i        drop the history (d1 becomes invalid)
//   sample_en_i  d0 valid this cycle
//   d0_i         current sample
//   level_i      trigger threshold
//   edge_fall_i  0 rising, 1 falling
//   trig_hit_o   crossing detected on this sample (combinational)
module scope_edge_detect
    import scope_trigger_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sys_clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              sample_en_i,
    input  logic [DATA_W-1:0] d0_i,
    input  logic [DATA_W-1:0] level_i,
    input  logic              edge_fall_i,
    output logic              trig_hit_o
);

    logic [DATA_W-1:0] d1_q;
    logic              valid_q;
    logic              rise;
    logic              fall;

    always_ff @(posedge sys_clk_i) begin
        if (rst_i || clr_i) begin
            d1_q    <= '0;
            valid_q <= 1'b0;
        end else if (sample_en_i) begin
            d1_q    <= d0_i;
            valid_q <= 1'b1;
        end
    end

    always_comb begin
        rise       = (d1_q < level_i) && (d0_i >= level_i);
        fall       = (d1_q > level_i) && (d0_i <= level_i);
        trig_hit_o = valid_q && sample_en_i && (edge_fall_i ? fall : rise);
    end

endmodule

// File: rtl/scope_trigger_ctrl.sv
// Capture sequencer for the scope sample RAM.
// Writes ADC samples into a ring buffer, keeps PRE_TRIG samples ahead of the
// trigger, fills the rest of the record after it, then freezes the buffer
// until the display reports the frame consumed.
// Ports:
//   sys_clk, rst                 clock, synchronous active-high reset
//   sample_en, ad_data           ADC sample strobe and data
//   arm                          restart capture in single mode
//   trig_mode, trig_edge,
//   trig_level                   trigger configuration (sampled live)
//   holdoff, auto_timeout        re-arm delay (cycles), auto timeout (ticks)
//   frame_done                   display finished reading the record
//   buf_wren/wraddr/wrdata       RAM write port (registered)
//   trig_addr                    oldest sample of the frozen record
//   capture_done                 record valid and stable
//   auto_trig                    last record was forced by timeout
//   busy                         capturing
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting to start (auto/normal immediately, single on arm)
// S_PRETRIG | filling the pre-trigger part of the ring
// S_ARMED   | writing samples and looking for a trigger
// S_POST    | writing the samples that follow the trigger
// S_DONE    | record frozen, waiting for frame_done
// S_HOLDOFF | record still frozen, counting down to the next capture
module scope_trigger_ctrl
    import scope_trigger_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PRE_TRIG = PRE_TRIG_DEF
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic              trig_edge,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [31:0]       holdoff,
    input  logic [31:0]       auto_timeout,
    input  logic              frame_done,
    output logic              buf_wren,
    output logic [ADDR_W-1:0] buf_wraddr,
    output logic [DATA_W-1:0] buf_wrdata,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              capture_done,
    output logic              auto_trig,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   PRE_LEN  = (ADDR_W+1)'(PRE_TRIG);
    localparam logic [ADDR_W:0]   POST_LEN = (ADDR_W+1)'(DEPTH - PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_TRIG);
    // With no pre-trigger samples the ring fill phase is skipped entirely.
    localparam state_e S_FILL = (PRE_TRIG == 0) ? S_ARMED : S_PRETRIG;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic                wren_q;
    logic [ADDR_W-1:0]   wraddr_q;
    logic [DATA_W-1:0]   wrdata_q;
    logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
    logic                auto_trig_q, auto_trig_d;
    logic [ADDR_W:0]     pre_cnt_q, pre_cnt_d;
    logic [ADDR_W:0]     post_cnt_q, post_cnt_d;
    logic [31:0]         hold_cnt_q, hold_cnt_d;
    logic [31:0]         tick_q, tick_d;
    logic                wr_go;
    logic                trig_hit;
    logic                forced;
    logic                hist_clr;

    assign wr_go    = sample_en && is_capture(state_q);
    assign hist_clr = !((state_q == S_PRETRIG) || (state_q == S_ARMED));

    scope_edge_detect #(
        .DATA_W (DATA_W)
    ) u_edge (
        .sys_clk_i   (sys_clk),
        .rst_i       (rst),
        .clr_i       (hist_clr),
        .sample_en_i (sample_en),
        .d0_i        (ad_data),
        .level_i     (trig_level),
        .edge_fall_i (trig_edge),
        .trig_hit_o  (trig_hit)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            wren_q      <= 1'b0;
            wraddr_q    <= '0;
            wrdata_q    <= '0;
            trig_addr_q <= '0;
            auto_trig_q <= 1'b0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            wren_q      <= wr_go;
            if (wr_go) begin
                wraddr_q <= ptr_q;
                wrdata_q <= ad_data;
                ptr_q    <= ptr_q + 1'b1;
            end
            trig_addr_q <= trig_addr_d;
            auto_trig_q <= auto_trig_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            tick_q      <= tick_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        trig_addr_d = trig_addr_q;
        auto_trig_d = auto_trig_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        tick_d      = tick_q;
        // 33-bit compare so auto_timeout = 2^32-1 cannot wrap the tick count.
        forced      = (trig_mode == MODE_AUTO) &&
                      (({1'b0, tick_q} + 33'd1) >= {1'b0, auto_timeout});

        case (state_q)
            S_IDLE: begin
                if (trig_mode != MODE_SINGLE || arm) begin
                    state_d = S_FILL;
                end
            end
            S_PRETRIG: begin
                if (sample_en) begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_d == PRE_LEN) begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (sample_en) begin
                    tick_d = tick_q + 32'd1;
                    if (trig_hit || forced) begin
                        // The trigger sample itself goes to ptr_q this cycle.
                        trig_addr_d = ptr_q - PRE_OFS;
                        auto_trig_d = !trig_hit;
                        state_d     = (POST_LEN == '0) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST: begin
                if (sample_en) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == POST_LEN) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (frame_done) begin
                    if (trig_mode == MODE_SINGLE) begin
                        state_d = S_IDLE;
                    end else if (holdoff == 32'd0) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_HOLDOFF;
                    end
                end
            end
            S_HOLDOFF: begin
                hold_cnt_d = hold_cnt_q + 32'd1;
                if (hold_cnt_d >= holdoff) begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every counter starts from zero in the state it is used in.
        if (state_d != state_q) begin
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            hold_cnt_d = '0;
            tick_d     = '0;
        end
    end

    assign buf_wren     = wren_q;
    assign buf_wraddr   = wraddr_q;
    assign buf_wrdata   = wrdata_q;
    assign trig_addr    = trig_addr_q;
    assign auto_trig    = auto_trig_q;
    assign capture_done = (state_q == S_DONE) || (state_q == S_HOLDOFF);
    assign busy         = is_capture(state_q);

endmodule

// File: tb/tb_scope_trigger_ctrl.sv
module tb_scope_trigger_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [7:0]  ad_data = '0;
    logic        arm = 1'b0;
    logic [1:0]  trig_mode = 2'd1;
    logic        trig_edge = 1'b0;
    logic [7:0]  trig_level = 8'd128;
    logic [31:0] holdoff = 32'd0;
    logic [31:0] auto_timeout = 32'd100000;
    logic        frame_done = 1'b0;
    logic        buf_wren;
    logic [9:0]  buf_wraddr;
    logic [7:0]  buf_wrdata;
    logic [9:0]  trig_addr;
    logic        capture_done;
    logic        auto_trig;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    int          n_wr = 0;
    int          idle_cnt;
    logic [9:0]  exp_ptr = '0;
    logic [9:0]  last_addr = '0;

    always #5 sys_clk = ~sys_clk;

    scope_trigger_ctrl dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .ad_data      (ad_data),
        .arm          (arm),
        .trig_mode    (trig_mode),
        .trig_edge    (trig_edge),
        .trig_level   (trig_level),
        .holdoff      (holdoff),
        .auto_timeout (auto_timeout),
        .frame_done   (frame_done),
        .buf_wren     (buf_wren),
        .buf_wraddr   (buf_wraddr),
        .buf_wrdata   (buf_wrdata),
        .trig_addr    (trig_addr),
        .capture_done (capture_done),
        .auto_trig    (auto_trig),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock with the given sample; every write that appears is checked
    // against the expected ring pointer and the data that was driven.
    task automatic step(input logic en, input logic [7:0] d);
        sample_en = en;
        ad_data   = d;
        @(posedge sys_clk);
        #1;
        if (buf_wren) begin
            chk("wr_addr", {22'b0, buf_wraddr}, {22'b0, exp_ptr});
            chk("wr_data", {24'b0, buf_wrdata}, {24'b0, d});
            last_addr = buf_wraddr;
            exp_ptr   = exp_ptr + 10'd1;
            n_wr++;
        end
        sample_en  = 1'b0;
        frame_done = 1'b0;
        arm        = 1'b0;
    endtask

    task automatic run_until_done(input logic [7:0] d, input int budget);
        int k = 0;
        while (!capture_done && k < budget) begin
            step(1'b1, d);
            k++;
        end
        chk("done_reached", {31'b0, capture_done}, 32'd1);
    endtask

    task automatic send_n(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) step(1'b1, d);
    endtask

    initial begin
        // reset state
        step(1'b0, 8'd0);
        step(1'b1, 8'd9);
        chk("rst_wren", {31'b0, buf_wren}, 32'd0);
        chk("rst_wraddr", {22'b0, buf_wraddr}, 32'd0);
        chk("rst_done", {31'b0, capture_done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_auto", {31'b0, auto_trig}, 32'd0);
        chk("rst_trig_addr", {22'b0, trig_addr}, 32'd0);
        rst = 1'b0;

        // 1: normal, rising, ramp
        step(1'b0, 8'd0);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        n_wr = 0;
        for (int i = 0; i < 3000 && !capture_done; i++) step(1'b1, 8'(i));
        chk("t1_done", {31'b0, capture_done}, 32'd1);
        chk("t1_trig_addr", {22'b0, trig_addr}, 32'd128);
        chk("t1_nwr", n_wr, 32'd1152);
        chk("t1_last", {22'b0, last_addr}, 32'd127);
        chk("t1_auto", {31'b0, auto_trig}, 32'd0);
        chk("t1_busy_done", {31'b0, busy}, 32'd0);
        send_n(8'd5, 3);
        chk("t1_drop_in_done", n_wr, 32'd1152);

        // 3: falling edge pairs
        trig_edge  = 1'b1;
        frame_done = 1'b1;
        step(1'b0, 8'd0);
        chk("t3_busy", {31'b0, busy}, 32'd1);
        chk("t3_released", {31'b0, capture_done}, 32'd0);
        n_wr = 0;
        send_n(8'd128, 256);
        step(1'b1, 8'd128);
        chk("t3_eq_pair", {22'b0, trig_addr}, 32'd128);
        step(1'b1, 8'd127);
        chk("t3_128_127", {22'b0, trig_addr}, 32'd128);
        step(1'b1, 8'd127);
        step(1'b1, 8'd129);
        chk("t3_rising_ignored", {22'b0, trig_addr}, 32'd128);
        step(1'b1, 8'd128);
        chk("t3_129_128", {22'b0, trig_addr}, 32'd132);
        run_until_done(8'd0, 2000);
        chk("t3_nwr", n_wr, 32'd1028);
        chk("t3_last", {22'b0, last_addr}, 32'd131);

        // 4: wrap, trigger sample at 100
        trig_edge  = 1'b0;
        frame_done = 1'b1;
        step(1'b0, 8'd0);
        n_wr = 0;
        send_n(8'd0, 256);
        for (int i = 0; i < 2000 && exp_ptr != 10'd100; i++) step(1'b1, 8'd0);
        step(1'b1, 8'd200);
        chk("t4_trig_addr", {22'b0, trig_addr}, 32'd868);
        run_until_done(8'd0, 2000);
        chk("t4_last", {22'b0, last_addr}, 32'd867);
        chk("t4_nwr", n_wr, 32'd1760);

        // 2: auto timeout
        trig_mode    = 2'd0;
        auto_timeout = 32'd2000;
        frame_done   = 1'b1;
        step(1'b0, 8'd0);
        n_wr = 0;
        run_until_done(8'd50, 5000);
        chk("t2_auto", {31'b0, auto_trig}, 32'd1);
        chk("t2_trig_addr", {22'b0, trig_addr}, 32'd819);
        chk("t2_nwr", n_wr, 32'd3023);
        chk("t2_last", {22'b0, last_addr}, 32'd818);

        // 5: single mode stays idle until arm
        trig_mode  = 2'd2;
        frame_done = 1'b1;
        step(1'b0, 8'd0);
        chk("t5_idle_done", {31'b0, capture_done}, 32'd0);
        n_wr = 0;
        send_n(8'd77, 5000);
        chk("t5_no_writes", n_wr, 32'd0);
        chk("t5_idle_busy", {31'b0, busy}, 32'd0);
        arm = 1'b1;
        step(1'b0, 8'd0);
        chk("t5_arm_busy", {31'b0, busy}, 32'd1);
        send_n(8'd0, 256);
        step(1'b1, 8'd200);
        chk("t5_trig_addr", {22'b0, trig_addr}, 32'd819);
        chk("t5_auto", {31'b0, auto_trig}, 32'd0);
        run_until_done(8'd0, 2000);
        chk("t5_nwr", n_wr, 32'd1024);
        chk("t5_last", {22'b0, last_addr}, 32'd818);

        // 5b: holdoff of 10 cycles in normal mode
        trig_mode  = 2'd1;
        holdoff    = 32'd10;
        frame_done = 1'b1;
        step(1'b0, 8'd0);
        n_wr = 0;
        idle_cnt = 0;
        for (int i = 0; i < 50 && !busy; i++) begin
            chk("t5_holdoff_done", {31'b0, capture_done}, 32'd1);
            idle_cnt++;
            step(1'b1, 8'd9);
        end
        chk("t5_holdoff_len", idle_cnt, 32'd10);
        chk("t5_holdoff_drop", n_wr, 32'd0);

        // 6: reset in the middle of POST
        send_n(8'd0, 256);
        step(1'b1, 8'd200);
        send_n(8'd0, 100);
        chk("t6_in_post", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        step(1'b1, 8'd0);
        rst = 1'b0;
        chk("t6_wren", {31'b0, buf_wren}, 32'd0);
        chk("t6_done", {31'b0, capture_done}, 32'd0);
        chk("t6_wraddr", {22'b0, buf_wraddr}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_trig_addr", {22'b0, trig_addr}, 32'd0);
        exp_ptr = '0;
        step(1'b0, 8'd0);
        n_wr = 0;
        send_n(8'd0, 256);
        step(1'b1, 8'd200);
        chk("t6_re_trig_addr", {22'b0, trig_addr}, 32'd0);
        run_until_done(8'd0, 2000);
        chk("t6_nwr", n_wr, 32'd1024);
        chk("t6_last", {22'b0, last_addr}, 32'd1023);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
